// File: rtl/frame_renderer_pkg.sv
// frame_renderer_pkg: framebuffer geometry, FSM states and the 3x5 hex font shared by the renderer.
package frame_renderer_pkg;
  localparam int FB_COLS = 40;
  localparam int FB_ROWS = 30;
  localparam int FB_BITS = FB_COLS * FB_ROWS;
  localparam int GLYPH_W = 3;
  localparam int GLYPH_H = 5;
  typedef enum logic [1:0] {IDLE, DRAW, PUBLISH} state_e;
  // Row 0 sits in bits [14:12]; within a row bit 2 is the leftmost pixel.
  localparam logic [14:0] FONT [16] = '{
    15'b111_101_101_101_111, 15'b010_110_010_010_111,
    15'b111_001_111_100_111, 15'b111_001_111_001_111,
    15'b101_101_111_001_001, 15'b111_100_111_001_111,
    15'b111_100_111_101_111, 15'b111_001_001_001_001,
    15'b111_101_111_101_111, 15'b111_101_111_001_111,
    15'b111_101_111_101_101, 15'b110_101_110_101_110,
    15'b111_100_100_100_111, 15'b110_101_101_101_110,
    15'b111_100_111_100_111, 15'b111_100_111_100_100
  };
endpackage

// File: rtl/hex_glyph_rom.sv
// hex_glyph_rom: one 3-pixel row of a hex digit glyph; blank below the glyph height.
module hex_glyph_rom
  import frame_renderer_pkg::*;
(
  input  logic [3:0]         digit,
  input  logic [2:0]         row,
  output logic [GLYPH_W-1:0] bits
);
  logic [3:0] sh;
  always_comb begin
    sh = 4'd12 - 4'(row) * 4'd3;
    bits = row >= 3'(GLYPH_H) ? '0 : GLYPH_W'(FONT[digit] >> sh);
  end
endmodule

// File: rtl/frame_renderer.sv
// frame_renderer: renders three column bytes as hex glyph pairs into a work buffer,
// then publishes the whole frame to the framebuffer in one edge.
module frame_renderer
  import frame_renderer_pkg::*;
#(
  parameter int X1 = 4,
  parameter int X2 = 16,
  parameter int X3 = 28
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic [2:0]         visible,
  input  logic [7:0]         letter1,
  input  logic [7:0]         letter2,
  input  logic [7:0]         letter3,
  input  logic [4:0]         ypos1,
  input  logic [4:0]         ypos2,
  input  logic [4:0]         ypos3,
  output logic [FB_BITS-1:0] framebuffer,
  output logic               busy,
  output logic               done,
  output logic               overrun
);
  if (X1 > 33 || X2 > 33 || X3 > 33) begin : g_bad_x
    $error("frame_renderer: glyph pair would exceed column 39");
  end
  state_e state_q, state_d;
  logic [2:0] r_q, r_d;
  logic dig_q, dig_d;
  logic [1:0] col_q, col_d;
  logic [2:0] vis_q, vis_d;
  logic [2:0][7:0] let_q, let_d;
  logic [2:0][4:0] ypos_q, ypos_d;
  logic [FB_BITS-1:0] work_q, work_d, fb_q, fb_d, mask;
  logic done_q, done_d, overrun_q, overrun_d;
  logic [7:0] letter;
  logic [3:0] digit;
  logic [GLYPH_W-1:0] bits;
  logic [5:0] xk, x, row;
  logic [10:0] pos;
  logic wr, last, accept, draw;
  hex_glyph_rom u_rom (.digit(digit), .row(r_q), .bits(bits));
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      r_q       <= '0;
      dig_q     <= 1'b0;
      col_q     <= '0;
      vis_q     <= '0;
      let_q     <= '0;
      ypos_q    <= '0;
      work_q    <= '0;
      fb_q      <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      dig_q     <= dig_d;
      col_q     <= col_d;
      vis_q     <= vis_d;
      let_q     <= let_d;
      ypos_q    <= ypos_d;
      work_q    <= work_d;
      fb_q      <= fb_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end
  always_comb begin
    last = col_q == 2'd2 && dig_q && r_q == 3'd4;
    state_d = state_q == IDLE ? (frame_start ? DRAW : IDLE) :
              state_q == DRAW ? (last ? PUBLISH : DRAW) : IDLE;
  end
  // Glyph pixel placement: bit 2 of the ROM row lands on the leftmost column x.
  always_comb begin
    accept = state_q == IDLE && frame_start;
    draw = state_q == DRAW;
    letter = let_q[col_q];
    digit = dig_q ? letter[3:0] : letter[7:4];
    xk = col_q == 2'd0 ? 6'(X1) : col_q == 2'd1 ? 6'(X2) : 6'(X3);
    x = xk + (dig_q ? 6'd4 : 6'd0);
    row = {1'b0, ypos_q[col_q]} + {3'b0, r_q};
    pos = 11'(row) * 11'd40 + 11'(x);
    mask = FB_BITS'({bits[0], bits[1], bits[2]}) << pos;
    wr = row < 6'(FB_ROWS) && vis_q[col_q];
    vis_d = accept ? visible : vis_q;
    let_d = accept ? {letter3, letter2, letter1} : let_q;
    ypos_d = accept ? {ypos3, ypos2, ypos1} : ypos_q;
    work_d = accept ? '0 : (draw && wr) ? (work_q | mask) : work_q;
    r_d = accept ? 3'd0 : draw ? (r_q == 3'd4 ? 3'd0 : r_q + 3'd1) : r_q;
    dig_d = accept ? 1'b0 : (draw && r_q == 3'd4) ? ~dig_q : dig_q;
    col_d = accept ? 2'd0 : (draw && r_q == 3'd4 && dig_q) ? col_q + 2'd1 : col_q;
    fb_d = state_q == PUBLISH ? work_q : fb_q;
    done_d = state_q == PUBLISH;
    overrun_d = frame_start && state_q != IDLE;
  end
  always_comb begin
    framebuffer = fb_q;
    busy = state_q != IDLE;
    done = done_q;
    overrun = overrun_q;
  end
endmodule

// File: tb/tb_frame_renderer.sv
// tb_frame_renderer: directed checks of frame_renderer timing, glyph placement, overrun and reset.
module tb_frame_renderer;
  logic clk = 1'b0;
  logic reset_n, frame_start;
  logic [2:0] visible;
  logic [7:0] letter1, letter2, letter3;
  logic [4:0] ypos1, ypos2, ypos3;
  logic [1199:0] fb, e;
  logic busy, done, overrun;
  int pass_cnt = 0, fail_cnt = 0, total = 0, ndone;
  localparam logic [14:0] G0 = 15'b111_101_101_101_111;
  localparam logic [14:0] G8 = 15'b111_101_111_101_111;
  localparam logic [14:0] GA = 15'b111_101_111_101_101;
  localparam logic [14:0] G5 = 15'b111_100_111_001_111;

  frame_renderer dut (
    .clock(clk), .reset_n(reset_n), .frame_start(frame_start), .visible(visible),
    .letter1(letter1), .letter2(letter2), .letter3(letter3),
    .ypos1(ypos1), .ypos2(ypos2), .ypos3(ypos3),
    .framebuffer(fb), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1199:0] obs, input logic [1199:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1199:0] put(input logic [1199:0] f, input int row, input int x,
                                        input logic [14:0] g);
    for (int i = 0; i < 5; i++)
      if (row + i < 30)
        for (int j = 0; j < 3; j++)
          if (g[14 - 3 * i - j]) f[(row + i) * 40 + x + j] = 1'b1;
    return f;
  endfunction

  task automatic accept();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("busy_after_accept", 1200'(busy), 1200'(1));
  endtask

  task automatic run_to_publish(input logic [1199:0] prev);
    repeat (30) step();
    chk("fb_held_before_publish", fb, prev);
    chk("busy_before_publish", 1200'(busy), 1200'(1));
    step();
    chk("done_at_publish", 1200'(done), 1200'(1));
    chk("busy_after_publish", 1200'(busy), 1200'(0));
  endtask

  initial begin
    reset_n = 1'b0;
    frame_start = 1'b0;
    visible = 3'b000;
    {letter1, letter2, letter3} = '0;
    {ypos1, ypos2, ypos3} = '0;
    repeat (3) step();
    chk("reset_fb", fb, '0);
    reset_n = 1'b1;
    // idle after reset
    for (int i = 0; i < 100; i++) begin
      step();
      chk("idle_quiet", {fb, busy, done, overrun}, '0);
    end
    // "80" at X1, top of screen
    visible = 3'b001; letter1 = 8'h80; ypos1 = 5'd0;
    accept();
    e = put(put('0, 0, 4, G8), 0, 8, G0);
    run_to_publish('0);
    chk("fb_80", fb, e);
    chk("popcount_80", 1200'($countones(fb)), 1200'(25));
    step();
    chk("done_drops", 1200'(done), 1200'(0));
    // "00" near bottom, clipped after two rows
    letter1 = 8'h00; ypos1 = 5'd28;
    accept();
    run_to_publish(e);
    e = '0;
    e[28*40+4] = 1'b1; e[28*40+5] = 1'b1; e[28*40+6] = 1'b1;
    e[28*40+8] = 1'b1; e[28*40+9] = 1'b1; e[28*40+10] = 1'b1;
    e[29*40+4] = 1'b1; e[29*40+6] = 1'b1; e[29*40+8] = 1'b1; e[29*40+10] = 1'b1;
    chk("fb_00_clip", fb, e);
    chk("row0_clear", 1200'(fb[39:0]), '0);
    step();
    // overrun mid-render, back-to-back accept at N+32
    letter1 = 8'h80; ypos1 = 5'd0;
    accept();
    ndone = 0;
    for (int k = 1; k <= 32; k++) begin
      if (k == 10 || k == 32) frame_start = 1'b1;
      if (k == 32) begin letter1 = 8'h08; ypos1 = 5'd2; end
      step();
      frame_start = 1'b0;
      if (done) ndone++;
      if (k == 10) chk("overrun_pulse", 1200'(overrun), 1200'(1));
      if (k == 11) chk("overrun_clears", 1200'(overrun), 1200'(0));
      if (k == 31) chk("done_n31", 1200'(done), 1200'(1));
    end
    chk("one_done", 1200'(ndone), 1200'(1));
    chk("reaccept_busy", 1200'(busy), 1200'(1));
    chk("reaccept_no_overrun", 1200'(overrun), 1200'(0));
    e = put(put('0, 0, 4, G8), 0, 8, G0);
    run_to_publish(e);
    chk("fb_reaccept", fb, put(put('0, 2, 4, G0), 2, 8, G8));
    step();
    // latched inputs; start during publish is ignored
    visible = 3'b010; letter2 = 8'h08; ypos2 = 5'd3;
    accept();
    repeat (4) step();
    letter2 = 8'hFF; visible = 3'b000;
    e = fb;
    repeat (26) step();
    chk("fb_held_n30", fb, e);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    e = put(put('0, 3, 16, G0), 3, 20, G8);
    chk("fb_latched_08", fb, e);
    chk("publish_overrun", 1200'(overrun), 1200'(1));
    step();
    chk("publish_start_ignored", 1200'(busy), 1200'(0));
    // async reset mid-render
    visible = 3'b001; letter1 = 8'hA5; ypos1 = 5'd10;
    accept();
    repeat (14) step();
    reset_n = 1'b0;
    #1;
    chk("rst_fb", fb, '0);
    chk("rst_busy", 1200'(busy), 1200'(0));
    #2 reset_n = 1'b1;
    step();
    chk("post_rst_idle", {fb, busy, done, overrun}, '0);
    accept();
    run_to_publish('0);
    chk("fb_after_rst", fb, put(put('0, 10, 4, GA), 10, 8, G5));
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
